// File: rtl/dcm_lock_sequencer_pkg.sv
// Shared state encoding and default timing constants for the frame-buffer DCM lock sequencer.
package dcm_lock_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_DRST   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam int DCM_RST_MIN     = 3;
  localparam int FB_RST_CYCLES   = 8;
  localparam int FB_LOCK_TIMEOUT = 65535;
  localparam int FB_SETTLE       = 256;
  localparam int FB_MAX_RETRIES  = 3;
  localparam int FB_CW           = 16;

endpackage

// File: rtl/dcm_lock_sequencer_sync2.sv
// Generic two-flop synchronizer; both stages clear to 0 on asynchronous active-low reset.
module dcm_lock_sequencer_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dcm_lock_sequencer.sv
// DCM reset/lock sequencer: pulses DCM RST, waits for lock with timeout, qualifies lock, retries, faults.
// Optional lock-loss counter enabled by defining DCM_LOSS_CNT_EN; otherwise loss_cnt is tied to 0.
module dcm_lock_sequencer
  import dcm_lock_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = FB_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = FB_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES = FB_SETTLE,
  parameter int MAX_RETRIES   = FB_MAX_RETRIES,
  parameter int CW            = FB_CW
) (
  input  logic       fclk,
  input  logic       rst_b,
  input  logic       locked,
  input  logic       clear_fault,
  output logic       dcm_rst,
  output logic       ready,
  output logic       sys_rst_b,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  // A degenerate pulse length falls back to the DCM's own minimum.
  localparam int RST_LEN = (RST_CYCLES < 2) ? DCM_RST_MIN : RST_CYCLES;
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_LEN - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          dcm_rst_q;
  logic          ready_q;
  logic          sys_rst_b_q;
  logic          fault_q;
  logic [1:0]    retry_q;
  logic          lk_s;
  logic          retries_spent;

  dcm_lock_sequencer_sync2 u_lock_sync (
    .clk_i  (fclk),
    .rst_ni (rst_b),
    .d_i    (locked),
    .q_o    (lk_s)
  );

  assign retries_spent = (int'(retry_q) + 1) >= MAX_RETRIES;

  always_ff @(posedge fclk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_DRST;
      cnt_q       <= '0;
      dcm_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      sys_rst_b_q <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= 2'd0;
    end else begin
      case (state_q)
        ST_DRST: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= ST_WAIT;
            cnt_q     <= '0;
            dcm_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          // Lock takes priority over a timeout landing on the same cycle.
          if (lk_s) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_q   <= (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
            cnt_q     <= '0;
            dcm_rst_q <= 1'b1;
            if (retries_spent) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_DRST;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!lk_s) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            sys_rst_b_q <= 1'b1;
            retry_q     <= 2'd0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            state_q     <= ST_DRST;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            sys_rst_b_q <= 1'b0;
            dcm_rst_q   <= 1'b1;
          end
        end
        ST_FAULT: begin
          if (clear_fault) begin
            state_q <= ST_DRST;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            retry_q <= 2'd0;
          end
        end
        default: begin
          state_q     <= ST_DRST;
          cnt_q       <= '0;
          dcm_rst_q   <= 1'b1;
          ready_q     <= 1'b0;
          sys_rst_b_q <= 1'b0;
          fault_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCM_LOSS_CNT_EN
  logic       loss_event;
  logic [7:0] loss_q;
  logic [7:0] loss_d;

  assign loss_event = (state_q == ST_RUN) && !lk_s;

  always_comb begin
    loss_d = loss_q;
    if (loss_event && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge fclk or negedge rst_b) begin
    if (!rst_b) begin
      loss_q <= 8'd0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

  assign dcm_rst   = dcm_rst_q;
  assign ready     = ready_q;
  assign sys_rst_b = sys_rst_b_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Self-checking bench for dcm_lock_sequencer: directed scenarios plus randomized lock traffic vs a phase/elapsed-time model.
module tb_dcm_lock_sequencer;

  localparam int RST_CYCLES    = 8;
  localparam int LOCK_TIMEOUT  = 150;
  localparam int SETTLE_CYCLES = 256;
  localparam int MAX_RETRIES   = 3;
  localparam int CW            = 16;
  localparam int LOCK_LATENCY  = 2 + SETTLE_CYCLES + 1;
`ifdef DCM_LOSS_CNT_EN
  localparam int LOSS_ON = 1;
`else
  localparam int LOSS_ON = 0;
`endif

  logic       fclk = 1'b0;
  logic       rst_b = 1'b1;
  logic       locked = 1'b0;
  logic       clear_fault = 1'b0;
  logic       dcm_rst;
  logic       ready;
  logic       sys_rst_b;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_vec = 0;
  int n_err = 0;

  dcm_lock_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES),
    .CW            (CW)
  ) dut (
    .fclk        (fclk),
    .rst_b       (rst_b),
    .locked      (locked),
    .clear_fault (clear_fault),
    .dcm_rst     (dcm_rst),
    .ready       (ready),
    .sys_rst_b   (sys_rst_b),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt)
  );

  always #5 fclk = ~fclk;

  // Reference: which phase we are in and how long we have been there.
  typedef enum {M_PULSE, M_WAIT, M_SETTLE, M_RUN, M_FAULT} phase_t;
  phase_t     m_phase;
  int         m_elapsed;
  int         m_attempts;
  int         m_losses;
  logic [1:0] m_delay;

  task automatic model_reset();
    m_phase    = M_PULSE;
    m_elapsed  = 0;
    m_attempts = 0;
    m_losses   = 0;
    m_delay    = 2'b00;
  endtask

  task automatic enter(input phase_t p);
    m_phase   = p;
    m_elapsed = 0;
  endtask

  task automatic model_step();
    logic seen;
    seen    = m_delay[1];
    m_delay = {m_delay[0], locked};
    m_elapsed++;
    case (m_phase)
      M_PULSE:  if (m_elapsed == RST_CYCLES) enter(M_WAIT);
      M_WAIT: begin
        if (seen) enter(M_SETTLE);
        else if (m_elapsed == LOCK_TIMEOUT) begin
          m_attempts++;
          if (m_attempts >= MAX_RETRIES) enter(M_FAULT);
          else enter(M_PULSE);
        end
      end
      M_SETTLE: begin
        if (!seen) enter(M_WAIT);
        else if (m_elapsed == SETTLE_CYCLES) begin
          m_attempts = 0;
          enter(M_RUN);
        end
      end
      M_RUN: if (!seen) begin
        m_losses++;
        enter(M_PULSE);
      end
      M_FAULT: if (clear_fault) begin
        m_attempts = 0;
        enter(M_PULSE);
      end
      default: enter(M_PULSE);
    endcase
  endtask

  function automatic logic [13:0] model_outs();
    logic [1:0] r;
    logic [7:0] l;
    r = (m_attempts > 3) ? 2'd3 : 2'(m_attempts);
    l = (LOSS_ON == 0) ? 8'd0 : ((m_losses > 255) ? 8'd255 : 8'(m_losses));
    return {(m_phase == M_PULSE) || (m_phase == M_FAULT), m_phase == M_RUN,
            m_phase == M_RUN, m_phase == M_FAULT, r, l};
  endfunction

  task automatic check_outs(input string tag);
    logic [13:0] obs;
    logic [13:0] exp;
    obs = {dcm_rst, ready, sys_rst_b, fault, retry_cnt, loss_cnt};
    exp = model_outs();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @%0t: observed {dcm_rst,ready,sys_rst_b,fault,retry,loss}=%h expected %h",
             tag, $time, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge fclk);
    if (rst_b) model_step();
    #1;
    check_outs(tag);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return dcm_rst;
      1:       return ready;
      default: return fault;
    endcase
  endfunction

  task automatic count_until(input int sel, input logic level, input int bound,
                             input string tag, output int n);
    n = 0;
    do begin
      tick(tag);
      n++;
    end while ((sig(sel) !== level) && (n < bound));
  endtask

  initial begin
    int  n;
    int  wait_len;
    int  hold;
    bit  seen1;
    bit  seen2;

    // Asynchronous reset before any clock edge.
    model_reset();
    #2 rst_b = 1'b0;
    #1 check_outs("reset_async");
    tick("reset_hold");
    tick("reset_hold");
    #2 rst_b = 1'b1;

    // Normal lock: 8-cycle pulse, lock 100 cycles later, ready 259 cycles after the rise.
    count_until(0, 1'b0, 50, "A_pulse", n);
    check_int("A_dcm_rst_len", n, RST_CYCLES);
    repeat (100) tick("A_wait");
    locked = 1'b1;
    count_until(1, 1'b1, 1000, "A_settle", n);
    check_int("A_ready_latency", n, LOCK_LATENCY);
    check_int("A_sys_rst_b", int'(sys_rst_b), 1);
    check_int("A_retry", int'(retry_cnt), 0);
    repeat ($urandom_range(10, 40)) tick("A_run");

    // Lock loss in RUN.
    locked = 1'b0;
    count_until(1, 1'b0, 10, "D_drop", n);
    check_int("D_ready_drop_latency", n, 3);
    check_int("D_sys_rst_b", int'(sys_rst_b), 0);
    check_int("D_loss_cnt", int'(loss_cnt), LOSS_ON);
    count_until(0, 1'b0, 50, "D_pulse", n);
    check_int("D_dcm_rst_len", n, RST_CYCLES);
    wait_len = $urandom_range(5, 120);
    repeat (wait_len) tick("D_wait");
    locked = 1'b1;
    count_until(1, 1'b1, 1000, "D_relock", n);
    check_int("D_relock_latency", n, LOCK_LATENCY);

    // Repeated timeouts into FAULT; stray clear_fault pulses must be ignored.
    locked = 1'b0;
    count_until(1, 1'b0, 10, "B_drop", n);
    seen1 = 0;
    seen2 = 0;
    n = 0;
    do begin
      clear_fault = ($urandom_range(0, 15) == 0);
      tick("B_retry");
      n++;
      if (retry_cnt == 2'd1) seen1 = 1;
      if (retry_cnt == 2'd2) seen2 = 1;
    end while ((fault !== 1'b1) && (n < 2000));
    clear_fault = 1'b0;
    check_int("B_cycles_to_fault", n, MAX_RETRIES * (RST_CYCLES + LOCK_TIMEOUT));
    check_int("B_saw_retry1", int'(seen1), 1);
    check_int("B_saw_retry2", int'(seen2), 1);
    check_int("B_fault", int'(fault), 1);
    check_int("B_dcm_rst", int'(dcm_rst), 1);
    check_int("B_ready", int'(ready), 0);
    for (int k = 0; k < 20; k++) begin
      locked = ($urandom_range(0, 1) == 1);
      tick("B_fault_hold");
    end
    locked = 1'b0;
    clear_fault = 1'b1;
    tick("B_clear");
    clear_fault = 1'b0;
    check_int("B_fault_cleared", int'(fault), 0);
    check_int("B_retry_cleared", int'(retry_cnt), 0);
    count_until(0, 1'b0, 50, "B_pulse", n);
    check_int("B_dcm_rst_len", n, RST_CYCLES);

    // Settle glitch: a single low cycle restarts qualification.
    repeat (20) tick("C_wait");
    locked = 1'b1;
    repeat (100) tick("C_settle");
    locked = 1'b0;
    tick("C_glitch");
    locked = 1'b1;
    count_until(1, 1'b1, 1000, "C_resettle", n);
    check_int("C_ready_latency", n, LOCK_LATENCY);
    check_int("C_retry", int'(retry_cnt), 0);

    // Asynchronous reset in the middle of SETTLE.
    locked = 1'b0;
    count_until(1, 1'b0, 10, "E_drop", n);
    count_until(0, 1'b0, 50, "E_pulse", n);
    repeat (10) tick("E_wait");
    locked = 1'b1;
    repeat (50) tick("E_settle");
    #2 rst_b = 1'b0;
    model_reset();
    #1 check_outs("E_async_reset");
    tick("E_reset_hold");
    tick("E_reset_hold");
    #2 rst_b = 1'b1;
    count_until(0, 1'b0, 50, "E_pulse_after", n);
    check_int("E_dcm_rst_len", n, RST_CYCLES);

    // Randomized lock traffic with occasional clear_fault requests.
    for (int seg = 0; seg < 40; seg++) begin
      locked = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 400);
      for (int k = 0; k < hold; k++) begin
        clear_fault = ($urandom_range(0, 31) == 0);
        tick("R_random");
      end
    end
    clear_fault = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
